// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg
//   Shared definitions for the sum_accumulator block:
//     - default width / block-length constants
//     - block state enum (IDLE, ACCUM, HOLD)
//     - width of the per-block word counter
package sum_acc_pkg;

  localparam int DEF_DATA_W    = 6;
  localparam int DEF_ACC_W     = 10;
  localparam int DEF_BLOCK_LEN = 4;

  // BLOCK_LEN is at most 15, so a 4-bit counter always suffices.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accumulator_acc_adder.sv
// acc_adder
//   Combinational ACC_W-bit add of the running total and a zero-extended
//   DATA_W-bit SUM word, with carry out and the overflow policy applied.
//   Compile-time option: SUM_ACC_SATURATE_EN
//     defined   -> on carry the result clamps to 2^ACC_W-1
//     undefined -> the result wraps modulo 2^ACC_W
// Ports:
//   acc_in    [ACC_W-1:0]  running total (0 when starting a block)
//   sum_in    [DATA_W-1:0] incoming SUM word
//   acc_out   [ACC_W-1:0]  new total after the overflow policy
//   carry_out              the raw add carried out of ACC_W bits
module acc_adder #(
  parameter int DATA_W = 6,
  parameter int ACC_W  = 10
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [DATA_W-1:0] sum_in,
  output logic [ACC_W-1:0]  acc_out,
  output logic              carry_out
);

  logic [ACC_W:0] full_sum;

  always_comb begin
    full_sum  = {1'b0, acc_in} + {{(ACC_W + 1 - DATA_W){1'b0}}, sum_in};
    carry_out = full_sum[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    // A clamped total plus any non-zero word carries again, so it stays clamped.
    acc_out = carry_out ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    acc_out = full_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Accumulates BLOCK_LEN accepted unsigned SUM words into one block total,
//   then holds the total until downstream takes it.
//   Compile-time option: SUM_ACC_SATURATE_EN (clamp instead of wrap on overflow).
//
//   Handshakes: a word transfers on a rising edge where in_valid && in_ready;
//   a result transfers on a rising edge where out_valid && out_ready. A source
//   keeps its data stable while valid is high and the transfer has not happened.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream word handshake, in_sum [DATA_W-1:0] data
//   clear                 synchronous abort of the current block (highest priority)
//   out_valid / out_ready result handshake; out_acc [ACC_W-1:0], out_ovf
//   busy                  state is not IDLE
//   dbg_state [1:0]       current FSM state (sum_acc_pkg::state_e encoding)
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  output logic              in_ready,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W-1:0] add_base;
  logic [ACC_W-1:0] add_result;
  logic             add_carry;
  logic [CNT_W-1:0] cnt_inc;

  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // The first word of a block loads rather than adds, so the base is zero in IDLE.
  assign add_base = (state_q == ACCUM) ? acc_q : '0;

  acc_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc_adder (
    .acc_in    (add_base),
    .sum_in    (in_sum),
    .acc_out   (add_result),
    .carry_out (add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_result;
          cnt_d   = CNT_W'(1);
          ovf_d   = add_carry;
          state_d = (CNT_W'(1) == LAST_CNT) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = add_result;
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | add_carry;
          state_d = (cnt_inc == LAST_CNT) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    // Abort wins over any coincident accept or result transfer.
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs decode directly from flops, so reset reaches them without a clock.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule
